// File: rtl/axil_decoder.sv
// ---------------------------------------------------------------------------
// axil_decoder
//
// Address-decoding demultiplexer for AXI4-Lite. It connects one upstream
// master to NUM_SLAVES downstream register slaves. Slave i owns the region
// BASE_ADDR + i * 2**REGION_BITS. Any access outside every region is answered
// locally with DECERR (2'b11), and no slave ever sees it.
//
// The read and write channels are independent, and each one allows a single
// outstanding transaction. Both channels may target the same slave at once.
//
// Ports (N = NUM_SLAVES, AW = ADDR_WIDTH):
//   i_clk, i_reset               clock; synchronous active-high reset
//   Upstream read:
//     i_s_axi_arvalid, o_s_axi_arready, i_s_axi_araddr[AW]
//     o_s_axi_rvalid, i_s_axi_rready, o_s_axi_rdata[32], o_s_axi_rresp[2]
//   Upstream write:
//     i_s_axi_awvalid, o_s_axi_awready, i_s_axi_awaddr[AW]
//     i_s_axi_wvalid, o_s_axi_wready, i_s_axi_wdata[32], i_s_axi_wstrb[4]
//     o_s_axi_bvalid, i_s_axi_bready, o_s_axi_bresp[2]
//   Downstream, broadcast to every slave:
//     o_m_axi_araddr, o_m_axi_awaddr, o_m_axi_wdata, o_m_axi_wstrb
//   Downstream, one bit per slave (one-hot outputs):
//     o_m_axi_{ar,aw,w}valid, i_m_axi_{ar,aw,w}ready
//     i_m_axi_rvalid, o_m_axi_rready, i_m_axi_bvalid, o_m_axi_bready
//     i_m_axi_rdata[N][32], i_m_axi_rresp[N][2], i_m_axi_bresp[N][2]
// ---------------------------------------------------------------------------
module axil_decoder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned NUM_SLAVES  = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned REGION_BITS = 12
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  // Upstream read address / data
  input  logic                        i_s_axi_arvalid,
  output logic                        o_s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]       i_s_axi_araddr,
  output logic                        o_s_axi_rvalid,
  input  logic                        i_s_axi_rready,
  output logic [31:0]                 o_s_axi_rdata,
  output logic [1:0]                  o_s_axi_rresp,
  // Upstream write address / data / response
  input  logic                        i_s_axi_awvalid,
  output logic                        o_s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]       i_s_axi_awaddr,
  input  logic                        i_s_axi_wvalid,
  output logic                        o_s_axi_wready,
  input  logic [31:0]                 i_s_axi_wdata,
  input  logic [3:0]                  i_s_axi_wstrb,
  output logic                        o_s_axi_bvalid,
  input  logic                        i_s_axi_bready,
  output logic [1:0]                  o_s_axi_bresp,
  // Downstream broadcast payload
  output logic [ADDR_WIDTH-1:0]       o_m_axi_araddr,
  output logic [ADDR_WIDTH-1:0]       o_m_axi_awaddr,
  output logic [31:0]                 o_m_axi_wdata,
  output logic [3:0]                  o_m_axi_wstrb,
  // Downstream per-slave handshakes
  output logic [NUM_SLAVES-1:0]       o_m_axi_arvalid,
  input  logic [NUM_SLAVES-1:0]       i_m_axi_arready,
  output logic [NUM_SLAVES-1:0]       o_m_axi_awvalid,
  input  logic [NUM_SLAVES-1:0]       i_m_axi_awready,
  output logic [NUM_SLAVES-1:0]       o_m_axi_wvalid,
  input  logic [NUM_SLAVES-1:0]       i_m_axi_wready,
  input  logic [NUM_SLAVES-1:0]       i_m_axi_rvalid,
  output logic [NUM_SLAVES-1:0]       o_m_axi_rready,
  input  logic [NUM_SLAVES-1:0][31:0] i_m_axi_rdata,
  input  logic [NUM_SLAVES-1:0][1:0]  i_m_axi_rresp,
  input  logic [NUM_SLAVES-1:0]       i_m_axi_bvalid,
  output logic [NUM_SLAVES-1:0]       o_m_axi_bready,
  input  logic [NUM_SLAVES-1:0][1:0]  i_m_axi_bresp
);

  localparam int unsigned IdxW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [1:0] RespDecErr = 2'b11;

  // -------------------------------------------------------------------------
  // Address decode. The offset is taken at full address width, so the region
  // index that results is compared before it is narrowed. High addresses
  // therefore cannot alias back onto a valid slave.
  // -------------------------------------------------------------------------
  function automatic logic f_hit(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ((off >> REGION_BITS) < ADDR_WIDTH'(NUM_SLAVES));
  endfunction

  function automatic logic [IdxW-1:0] f_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return IdxW'(off >> REGION_BITS);
  endfunction

  // -------------------------------------------------------------------------
  // Read channel
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {RIdle, RAddr, RData, RErr} r_state_e;

  r_state_e              r_rstate;
  r_state_e              w_rstate_next;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [IdxW-1:0]       r_ridx;
  logic                  w_ar_hs;

  always_comb begin
    w_rstate_next   = r_rstate;
    o_s_axi_arready = 1'b0;
    o_s_axi_rvalid  = 1'b0;
    o_s_axi_rdata   = '0;
    o_s_axi_rresp   = '0;
    o_m_axi_arvalid = '0;
    o_m_axi_rready  = '0;
    // While reset is high, every output stays at its reset value, including
    // those of a transaction that is still in flight.
    if (!i_reset) begin
      unique case (r_rstate)
        RIdle: begin
          o_s_axi_arready = 1'b1;
          if (i_s_axi_arvalid) begin
            w_rstate_next = f_hit(i_s_axi_araddr) ? RAddr : RErr;
          end
        end
        RAddr: begin
          o_m_axi_arvalid[r_ridx] = 1'b1;
          if (i_m_axi_arready[r_ridx]) begin
            w_rstate_next = RData;
          end
        end
        RData: begin
          o_s_axi_rvalid         = i_m_axi_rvalid[r_ridx];
          o_s_axi_rdata          = i_m_axi_rdata[r_ridx];
          o_s_axi_rresp          = i_m_axi_rresp[r_ridx];
          o_m_axi_rready[r_ridx] = i_s_axi_rready;
          if (i_m_axi_rvalid[r_ridx] && i_s_axi_rready) begin
            w_rstate_next = RIdle;
          end
        end
        RErr: begin
          o_s_axi_rvalid = 1'b1;
          o_s_axi_rresp  = RespDecErr;
          if (i_s_axi_rready) begin
            w_rstate_next = RIdle;
          end
        end
        default: w_rstate_next = RIdle;
      endcase
    end
  end

  assign w_ar_hs        = o_s_axi_arready && i_s_axi_arvalid;
  assign o_m_axi_araddr = r_araddr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rstate <= RIdle;
      r_araddr <= '0;
      r_ridx   <= '0;
    end else begin
      r_rstate <= w_rstate_next;
      if (w_ar_hs) begin
        r_araddr <= i_s_axi_araddr;
        r_ridx   <= f_idx(i_s_axi_araddr);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Write channel
  // AW and W are captured independently while the channel is idle. Once both
  // are held, the decision between forwarding and DECERR is made from the
  // latched hit flag.
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {WIdle, WFwd, WResp, WErr} w_state_e;

  w_state_e              r_wstate;
  w_state_e              w_wstate_next;
  logic                  r_aw_got;
  logic                  r_w_got;
  logic                  r_aw_pend;
  logic                  r_w_pend;
  logic                  r_whit;
  logic [IdxW-1:0]       r_widx;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_both_got;
  logic                  w_m_aw_done;
  logic                  w_m_w_done;

  assign w_both_got = r_aw_got && r_w_got;

  always_comb begin
    w_wstate_next   = r_wstate;
    o_s_axi_awready = 1'b0;
    o_s_axi_wready  = 1'b0;
    o_s_axi_bvalid  = 1'b0;
    o_s_axi_bresp   = '0;
    o_m_axi_awvalid = '0;
    o_m_axi_wvalid  = '0;
    o_m_axi_bready  = '0;
    w_m_aw_done     = 1'b0;
    w_m_w_done      = 1'b0;
    if (!i_reset) begin
      unique case (r_wstate)
        WIdle: begin
          o_s_axi_awready = !r_aw_got;
          o_s_axi_wready  = !r_w_got;
          if (w_both_got) begin
            w_wstate_next = r_whit ? WFwd : WErr;
          end
        end
        WFwd: begin
          // Address and data each finish on their own handshake.
          o_m_axi_awvalid[r_widx] = r_aw_pend;
          o_m_axi_wvalid[r_widx]  = r_w_pend;
          w_m_aw_done = !r_aw_pend || i_m_axi_awready[r_widx];
          w_m_w_done  = !r_w_pend || i_m_axi_wready[r_widx];
          if (w_m_aw_done && w_m_w_done) begin
            w_wstate_next = WResp;
          end
        end
        WResp: begin
          o_s_axi_bvalid         = i_m_axi_bvalid[r_widx];
          o_s_axi_bresp          = i_m_axi_bresp[r_widx];
          o_m_axi_bready[r_widx] = i_s_axi_bready;
          if (i_m_axi_bvalid[r_widx] && i_s_axi_bready) begin
            w_wstate_next = WIdle;
          end
        end
        WErr: begin
          o_s_axi_bvalid = 1'b1;
          o_s_axi_bresp  = RespDecErr;
          if (i_s_axi_bready) begin
            w_wstate_next = WIdle;
          end
        end
        default: w_wstate_next = WIdle;
      endcase
    end
  end

  assign w_aw_hs        = o_s_axi_awready && i_s_axi_awvalid;
  assign w_w_hs         = o_s_axi_wready && i_s_axi_wvalid;
  assign o_m_axi_awaddr = r_awaddr;
  assign o_m_axi_wdata  = r_wdata;
  assign o_m_axi_wstrb  = r_wstrb;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wstate  <= WIdle;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_aw_pend <= 1'b0;
      r_w_pend  <= 1'b0;
      r_whit    <= 1'b0;
      r_widx    <= '0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_wstate <= w_wstate_next;
      if (w_aw_hs) begin
        r_aw_got <= 1'b1;
        r_awaddr <= i_s_axi_awaddr;
        r_widx   <= f_idx(i_s_axi_awaddr);
        r_whit   <= f_hit(i_s_axi_awaddr);
      end
      if (w_w_hs) begin
        r_w_got <= 1'b1;
        r_wdata <= i_s_axi_wdata;
        r_wstrb <= i_s_axi_wstrb;
      end
      // Leaving idle: release the capture flags and arm both downstream
      // valids. The pending flags are only used on the forwarding path.
      if (r_wstate == WIdle && w_both_got) begin
        r_aw_got  <= 1'b0;
        r_w_got   <= 1'b0;
        r_aw_pend <= r_whit;
        r_w_pend  <= r_whit;
      end
      if (r_wstate == WFwd) begin
        if (r_aw_pend && i_m_axi_awready[r_widx]) begin
          r_aw_pend <= 1'b0;
        end
        if (r_w_pend && i_m_axi_wready[r_widx]) begin
          r_w_pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_decoder.sv
// ---------------------------------------------------------------------------
// tb_axil_decoder
//
// Directed testbench for axil_decoder, using its default parameters:
// 4 slaves with 4 KiB regions starting at address 0. The downstream slaves
// are driven by hand in each scenario task. Outputs are sampled 2 time units
// after the rising edge, and inputs change 1 time unit after it.
// ---------------------------------------------------------------------------
module tb_axil_decoder;

  logic clk;
  logic reset;

  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_awvalid, s_awready;
  logic [31:0] s_awaddr;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid, s_bready;
  logic [1:0]  s_bresp;

  logic [31:0]      m_araddr, m_awaddr, m_wdata;
  logic [3:0]       m_wstrb;
  logic [3:0]       m_arvalid, m_arready, m_awvalid, m_awready, m_wvalid, m_wready;
  logic [3:0]       m_rvalid, m_rready, m_bvalid, m_bready;
  logic [3:0][31:0] m_rdata;
  logic [3:0][1:0]  m_rresp, m_bresp;

  int checks = 0;
  int errors = 0;

  axil_decoder dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_s_axi_arvalid (s_arvalid),
    .o_s_axi_arready (s_arready),
    .i_s_axi_araddr  (s_araddr),
    .o_s_axi_rvalid  (s_rvalid),
    .i_s_axi_rready  (s_rready),
    .o_s_axi_rdata   (s_rdata),
    .o_s_axi_rresp   (s_rresp),
    .i_s_axi_awvalid (s_awvalid),
    .o_s_axi_awready (s_awready),
    .i_s_axi_awaddr  (s_awaddr),
    .i_s_axi_wvalid  (s_wvalid),
    .o_s_axi_wready  (s_wready),
    .i_s_axi_wdata   (s_wdata),
    .i_s_axi_wstrb   (s_wstrb),
    .o_s_axi_bvalid  (s_bvalid),
    .i_s_axi_bready  (s_bready),
    .o_s_axi_bresp   (s_bresp),
    .o_m_axi_araddr  (m_araddr),
    .o_m_axi_awaddr  (m_awaddr),
    .o_m_axi_wdata   (m_wdata),
    .o_m_axi_wstrb   (m_wstrb),
    .o_m_axi_arvalid (m_arvalid),
    .i_m_axi_arready (m_arready),
    .o_m_axi_awvalid (m_awvalid),
    .i_m_axi_awready (m_awready),
    .o_m_axi_wvalid  (m_wvalid),
    .i_m_axi_wready  (m_wready),
    .i_m_axi_rvalid  (m_rvalid),
    .o_m_axi_rready  (m_rready),
    .i_m_axi_rdata   (m_rdata),
    .i_m_axi_rresp   (m_rresp),
    .i_m_axi_bvalid  (m_bvalid),
    .o_m_axi_bready  (m_bready),
    .i_m_axi_bresp   (m_bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_arvalid = 0; s_araddr = '0; s_rready = 0;
    s_awvalid = 0; s_awaddr = '0; s_wvalid = 0; s_wdata = '0; s_wstrb = '0;
    s_bready  = 0;
    m_arready = '0; m_awready = '0; m_wready = '0;
    m_rvalid  = '0; m_bvalid  = '0;
    m_rdata   = '0; m_rresp   = '0; m_bresp = '0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    #1;
    checks++;
    if ({s_arready, s_awready, s_wready} !== 3'b000) begin
      errors++; $display("FAIL rst_readys: got %b want 000", {s_arready, s_awready, s_wready});
    end
    checks++;
    if ({s_rvalid, s_bvalid, m_arvalid, m_awvalid, m_wvalid} !== 14'h0) begin
      errors++; $display("FAIL rst_valids: got %h want 0",
                         {s_rvalid, s_bvalid, m_arvalid, m_awvalid, m_wvalid});
    end
    checks++;
    if ({s_rdata, s_rresp, s_bresp} !== 36'h0) begin
      errors++; $display("FAIL rst_data: got %h want 0", {s_rdata, s_rresp, s_bresp});
    end
    reset = 0;
    tick();
    #1;
    checks++;
    if ({s_arready, s_awready, s_wready} !== 3'b111) begin
      errors++; $display("FAIL rst_release_readys: got %b want 111",
                         {s_arready, s_awready, s_wready});
    end
  endtask

  // Reads address 'addr' from slave 'sl', which answers with data 'd' and
  // OKAY. The slave accepts the address at once.
  task automatic do_read(input logic [31:0] addr, input int sl, input logic [31:0] d,
                         input string nm);
    logic [3:0] oh;
    oh = 4'b0001 << sl;
    s_araddr = addr; s_arvalid = 1; #1;
    checks++;
    if (s_arready !== 1'b1) begin
      errors++; $display("FAIL %s_arready: got %b want 1", nm, s_arready);
    end
    tick();
    s_arvalid = 0; #1;
    checks++;
    if (m_arvalid !== oh || m_araddr !== addr) begin
      errors++; $display("FAIL %s_m_ar: got %b/%h want %b/%h", nm, m_arvalid, m_araddr, oh, addr);
    end
    m_arready[sl] = 1;
    tick();
    m_arready = '0;
    m_rvalid[sl] = 1; m_rdata[sl] = d; m_rresp[sl] = 2'b00; s_rready = 1; #1;
    checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== d || s_rresp !== 2'b00 || m_rready !== oh) begin
      errors++; $display("FAIL %s_rdata: got %b %h %b %b want 1 %h 00 %b",
                         nm, s_rvalid, s_rdata, s_rresp, m_rready, d, oh);
    end
    tick();
    m_rvalid = '0; m_rdata = '0; s_rready = 0; #1;
    checks++;
    if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin
      errors++; $display("FAIL %s_done: got rvalid %b arready %b want 0 1", nm, s_rvalid, s_arready);
    end
  endtask

  task automatic test_read_hit();
    do_read(32'h0000_1004, 1, 32'hDEAD_BEEF, "rd_hit");
  endtask

  task automatic test_write_w_first();
    s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wvalid = 1; #1;
    checks++;
    if (s_wready !== 1'b1) begin
      errors++; $display("FAIL wr_wready: got %b want 1", s_wready);
    end
    tick();
    s_wvalid = 0; #1;
    checks++;
    if (s_wready !== 1'b0 || s_awready !== 1'b1) begin
      errors++; $display("FAIL wr_w_held: got wready %b awready %b want 0 1", s_wready, s_awready);
    end
    tick();
    s_awaddr = 32'h0000_2010; s_awvalid = 1;
    tick();
    s_awvalid = 0;
    for (int i = 0; i < 8 && m_awvalid == 4'b0000; i++) tick();
    #1;
    checks++;
    if (m_awvalid !== 4'b0100 || m_wvalid !== 4'b0100) begin
      errors++; $display("FAIL wr_m_valid: got %b/%b want 0100/0100", m_awvalid, m_wvalid);
    end
    checks++;
    if (m_awaddr !== 32'h2010 || m_wdata !== 32'h1234_5678 || m_wstrb !== 4'hF) begin
      errors++; $display("FAIL wr_payload: got %h %h %h want 2010 12345678 f",
                         m_awaddr, m_wdata, m_wstrb);
    end
    m_awready[2] = 1; m_wready[2] = 1;
    tick();
    m_awready = '0; m_wready = '0;
    m_bvalid[2] = 1; m_bresp[2] = 2'b00; s_bready = 1; #1;
    checks++;
    if (m_awvalid !== 4'b0000 || m_wvalid !== 4'b0000) begin
      errors++; $display("FAIL wr_valid_drop: got %b/%b want 0000/0000", m_awvalid, m_wvalid);
    end
    checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || m_bready !== 4'b0100) begin
      errors++; $display("FAIL wr_bresp: got %b %b %b want 1 00 0100", s_bvalid, s_bresp, m_bready);
    end
    tick();
    m_bvalid = '0; s_bready = 0; #1;
    checks++;
    if (s_bvalid !== 1'b0) begin
      errors++; $display("FAIL wr_done: got bvalid %b want 0", s_bvalid);
    end
  endtask

  task automatic test_miss();
    logic [3:0] seen;
    seen = '0;
    s_araddr = 32'h0000_4000; s_arvalid = 1;
    tick();
    s_arvalid = 0; #1;
    checks++;
    if (s_rvalid !== 1'b1 || s_rresp !== 2'b11 || s_rdata !== 32'h0) begin
      errors++; $display("FAIL rd_miss: got %b %b %h want 1 11 0", s_rvalid, s_rresp, s_rdata);
    end
    seen |= m_arvalid;
    tick();
    seen |= m_arvalid;
    s_rready = 1;
    tick();
    s_rready = 0; #1;
    seen |= m_arvalid;
    checks++;
    if (s_rvalid !== 1'b0 || seen !== 4'b0000) begin
      errors++; $display("FAIL rd_miss_end: got rvalid %b arvalid_seen %b want 0 0000", s_rvalid, seen);
    end
    seen = '0;
    s_awaddr = 32'h0000_4000; s_awvalid = 1; s_wdata = 32'hBAD0_BAD0; s_wstrb = 4'hF; s_wvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    for (int i = 0; i < 8 && !s_bvalid; i++) begin
      seen |= m_awvalid | m_wvalid;
      tick();
    end
    #1;
    seen |= m_awvalid | m_wvalid;
    checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== 2'b11 || seen !== 4'b0000) begin
      errors++; $display("FAIL wr_miss: got %b %b seen %b want 1 11 0000", s_bvalid, s_bresp, seen);
    end
    s_bready = 1;
    tick();
    s_bready = 0; #1;
    checks++;
    if (s_bvalid !== 1'b0) begin
      errors++; $display("FAIL wr_miss_end: got bvalid %b want 0", s_bvalid);
    end
  endtask

  task automatic test_stall();
    int held;
    logic bad;
    held = 0;
    bad = 0;
    s_araddr = 32'h0000_0008; s_arvalid = 1;
    tick();
    s_arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (m_arvalid == 4'b0001) held++;
      tick();
    end
    m_arready[0] = 1; #1;
    checks++;
    if (held != 5 || m_arvalid !== 4'b0001) begin
      errors++; $display("FAIL stall_arvalid_hold: got %0d cycles, now %b want 5, 0001", held, m_arvalid);
    end
    tick();
    m_arready = '0; #1;
    checks++;
    if (m_arvalid !== 4'b0000) begin
      errors++; $display("FAIL stall_arvalid_drop: got %b want 0000", m_arvalid);
    end
    for (int i = 0; i < 2; i++) begin
      if (s_rvalid !== 1'b0) bad = 1;
      tick();
    end
    m_rvalid[0] = 1; m_rdata[0] = 32'hCAFE_F00D; m_rresp[0] = 2'b01; s_rready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (s_rvalid !== 1'b1 || s_rdata !== 32'hCAFE_F00D || m_rready !== 4'b0000) bad = 1;
      tick();
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL stall_rdata_stable: got unstable=%b want 0", bad);
    end
    s_rready = 1; #1;
    checks++;
    if (m_rready !== 4'b0001 || s_rdata !== 32'hCAFE_F00D || s_rresp !== 2'b01) begin
      errors++; $display("FAIL stall_r_hs: got %b %h %b want 0001 cafef00d 01", m_rready, s_rdata, s_rresp);
    end
    tick();
    m_rvalid = '0; m_rdata = '0; m_rresp = '0; s_rready = 0; #1;
    checks++;
    if (s_rvalid !== 1'b0) begin
      errors++; $display("FAIL stall_done: got rvalid %b want 0", s_rvalid);
    end
  endtask

  task automatic test_concurrent();
    logic [3:0] sa, saw, sw, srr, sbr;
    int r_cnt, b_cnt;
    logic [31:0] r_data, g_awaddr, g_wdata;
    logic [3:0] g_wstrb;
    logic [1:0] b_resp;
    sa = '0; saw = '0; sw = '0; srr = '0; sbr = '0;
    r_cnt = 0; b_cnt = 0; r_data = '0; g_awaddr = '0; g_wdata = '0; g_wstrb = '0; b_resp = 2'bxx;
    s_araddr = 32'h0000_3000; s_arvalid = 1;
    s_awaddr = 32'h0000_0040; s_awvalid = 1;
    s_wdata = 32'hA5A5_5A5A; s_wstrb = 4'h3; s_wvalid = 1;
    tick();
    s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
    m_arready[3] = 1; m_rvalid[3] = 1; m_rdata[3] = 32'h3333_0003; m_rresp[3] = 2'b00;
    m_awready[0] = 1; m_wready[0] = 1; m_bvalid[0] = 1; m_bresp[0] = 2'b00;
    s_rready = 1; s_bready = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      sa |= m_arvalid; saw |= m_awvalid; sw |= m_wvalid; srr |= m_rready; sbr |= m_bready;
      if (s_rvalid) begin r_cnt++; r_data = s_rdata; end
      if (s_bvalid) begin b_cnt++; b_resp = s_bresp; end
      if (m_awvalid[0]) g_awaddr = m_awaddr;
      if (m_wvalid[0]) begin g_wdata = m_wdata; g_wstrb = m_wstrb; end
      tick();
    end
    idle_inputs();
    checks++;
    if (r_cnt != 1 || r_data !== 32'h3333_0003) begin
      errors++; $display("FAIL cc_read: got %0d beats data %h want 1 33330003", r_cnt, r_data);
    end
    checks++;
    if (b_cnt != 1 || b_resp !== 2'b00) begin
      errors++; $display("FAIL cc_bresp: got %0d resp %b want 1 00", b_cnt, b_resp);
    end
    checks++;
    if (g_awaddr !== 32'h40 || g_wdata !== 32'hA5A5_5A5A || g_wstrb !== 4'h3) begin
      errors++; $display("FAIL cc_payload: got %h %h %h want 40 a5a55a5a 3", g_awaddr, g_wdata, g_wstrb);
    end
    checks++;
    if ({sa, saw, sw, srr, sbr} !== {4'b1000, 4'b0001, 4'b0001, 4'b1000, 4'b0001}) begin
      errors++; $display("FAIL cc_onehot: got %b %b %b %b %b want 1000 0001 0001 1000 0001",
                         sa, saw, sw, srr, sbr);
    end
  endtask

  task automatic test_reset_mid();
    logic leak;
    leak = 0;
    s_araddr = 32'h0000_1000; s_arvalid = 1;
    s_awaddr = 32'h0000_2000; s_awvalid = 1; s_wdata = 32'h7777_7777; s_wstrb = 4'hF; s_wvalid = 1;
    tick();
    s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
    tick();
    #1;
    checks++;
    if (m_arvalid !== 4'b0010 || m_awvalid !== 4'b0100 || m_wvalid !== 4'b0100) begin
      errors++; $display("FAIL rm_pre: got %b %b %b want 0010 0100 0100", m_arvalid, m_awvalid, m_wvalid);
    end
    reset = 1;
    tick();
    reset = 0; #1;
    checks++;
    if ({m_arvalid, m_awvalid, m_wvalid, s_rvalid, s_bvalid} !== 14'h0) begin
      errors++; $display("FAIL rm_valids: got %h want 0",
                         {m_arvalid, m_awvalid, m_wvalid, s_rvalid, s_bvalid});
    end
    checks++;
    if ({s_arready, s_awready, s_wready} !== 3'b111) begin
      errors++; $display("FAIL rm_idle: got %b want 111", {s_arready, s_awready, s_wready});
    end
    m_rvalid[1] = 1; m_bvalid[2] = 1; s_rready = 1; s_bready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (s_rvalid || s_bvalid || m_arvalid != 0 || m_awvalid != 0) leak = 1;
      tick();
    end
    idle_inputs();
    checks++;
    if (leak !== 1'b0) begin
      errors++; $display("FAIL rm_no_stale_resp: got leak=%b want 0", leak);
    end
    tick();
    do_read(32'h0000_1010, 1, 32'h1111_2222, "rm_read");
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_read_hit();
    tick();
    test_write_w_first();
    tick();
    test_miss();
    tick();
    test_stall();
    tick();
    test_concurrent();
    tick();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
